// File: rtl/arm_pkg.sv
// Shared definitions for the ARM968E-S-style core: execute command encodings,
// field widths and the packed control word carried from decode into execute.
package arm_pkg;

    localparam int REG_ADDR_W = 4;

    // ExecuteCommand encodings produced by the control unit
    localparam logic [3:0] EXE_NOP = 4'b0000;
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;

    typedef struct packed {
        logic       wb_en;
        logic       mem_r_en;
        logic       mem_w_en;
        logic       b;
        logic       s;
        logic [3:0] exe_cmd;
    } id_ex_ctrl_t;

    localparam int CTRL_W = $bits(id_ex_ctrl_t);

    // A bubble must never write back, touch memory or branch, so its control
    // word is forced to all zeros.
    function automatic id_ex_ctrl_t gate_ctrl(input id_ex_ctrl_t ctrl, input logic valid);
        id_ex_ctrl_t result;
        result = valid ? ctrl : '0;
        return result;
    endfunction

endpackage

// File: rtl/id_ex_stage_reg_pipe_reg.sv
// Generic W-bit pipeline register with synchronous reset, clear (flush) and
// hold (freeze). Reset beats clear, clear beats hold.
module pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         hold_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    // Next-state selection: clear to zero, keep contents, or take new data
    always_comb begin
        data_d = data_q;
        if (clr_i) begin
            data_d = '0;
        end else if (!hold_i) begin
            data_d = d_i;
        end
    end

    // State register with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures the decoded control word, valid bit and
// operands each cycle; flush turns the slot into a bubble, freeze holds it.
module id_ex_stage_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  freeze,
    input  logic                  valid_in,
    input  logic                  wb_en_in,
    input  logic                  mem_r_en_in,
    input  logic                  mem_w_en_in,
    input  logic                  b_in,
    input  logic                  s_in,
    input  logic [3:0]            exe_cmd_in,
    input  logic [DATA_W-1:0]     pc_in,
    input  logic [DATA_W-1:0]     val_rn_in,
    input  logic [DATA_W-1:0]     val_rm_in,
    input  logic                  imm_in,
    input  logic [11:0]           shift_operand_in,
    input  logic [23:0]           signed_imm_24_in,
    input  logic [REG_ADDR_W-1:0] dest_in,
    input  logic [REG_ADDR_W-1:0] src1_in,
    input  logic [REG_ADDR_W-1:0] src2_in,
    input  logic                  c_in,
    output logic                  valid_out,
    output logic                  wb_en_out,
    output logic                  mem_r_en_out,
    output logic                  mem_w_en_out,
    output logic                  b_out,
    output logic                  s_out,
    output logic [3:0]            exe_cmd_out,
    output logic [DATA_W-1:0]     pc_out,
    output logic [DATA_W-1:0]     val_rn_out,
    output logic [DATA_W-1:0]     val_rm_out,
    output logic                  imm_out,
    output logic [11:0]           shift_operand_out,
    output logic [23:0]           signed_imm_24_out,
    output logic [REG_ADDR_W-1:0] dest_out,
    output logic [REG_ADDR_W-1:0] src1_out,
    output logic [REG_ADDR_W-1:0] src2_out,
    output logic                  c_out
);

    import arm_pkg::id_ex_ctrl_t;
    import arm_pkg::CTRL_W;
    import arm_pkg::gate_ctrl;

    localparam int DATA_BUNDLE_W = 3 * DATA_W + 1 + 12 + 24 + 3 * REG_ADDR_W + 1;

    id_ex_ctrl_t              ctrl_raw;
    id_ex_ctrl_t              ctrl_gated;
    id_ex_ctrl_t              ctrl_q;
    logic [CTRL_W:0]          ctrl_vec_q;
    logic [DATA_BUNDLE_W-1:0] data_bundle_d;
    logic [DATA_BUNDLE_W-1:0] data_bundle_q;

    // Assemble the control word and zero it when decode holds a bubble
    always_comb begin
        ctrl_raw          = '0;
        ctrl_raw.wb_en    = wb_en_in;
        ctrl_raw.mem_r_en = mem_r_en_in;
        ctrl_raw.mem_w_en = mem_w_en_in;
        ctrl_raw.b        = b_in;
        ctrl_raw.s        = s_in;
        ctrl_raw.exe_cmd  = exe_cmd_in;
        ctrl_gated        = gate_ctrl(ctrl_raw, valid_in);
    end

    // Carry travels with the data so ADC/SBC see the flag as of decode time
    assign data_bundle_d = {pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in,
                            signed_imm_24_in, dest_in, src1_in, src2_in, c_in};

    pipe_reg #(.W(CTRL_W + 1)) u_ctrl_reg (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (flush),
        .hold_i (freeze),
        .d_i    ({ctrl_gated, valid_in}),
        .q_o    (ctrl_vec_q)
    );

    pipe_reg #(.W(DATA_BUNDLE_W)) u_data_reg (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (flush),
        .hold_i (freeze),
        .d_i    (data_bundle_d),
        .q_o    (data_bundle_q)
    );

    assign {ctrl_q, valid_out} = ctrl_vec_q;

    assign wb_en_out    = ctrl_q.wb_en;
    assign mem_r_en_out = ctrl_q.mem_r_en;
    assign mem_w_en_out = ctrl_q.mem_w_en;
    assign b_out        = ctrl_q.b;
    assign s_out        = ctrl_q.s;
    assign exe_cmd_out  = ctrl_q.exe_cmd;

    assign {pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out,
            signed_imm_24_out, dest_out, src1_out, src2_out, c_out} = data_bundle_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_id_ex_stage_reg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 4;

    logic                  clk = 1'b0;
    logic                  rst, flush, freeze, valid_in;
    logic                  wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in;
    logic [3:0]            exe_cmd_in;
    logic [DATA_W-1:0]     pc_in, val_rn_in, val_rm_in;
    logic                  imm_in;
    logic [11:0]           shift_operand_in;
    logic [23:0]           signed_imm_24_in;
    logic [REG_ADDR_W-1:0] dest_in, src1_in, src2_in;
    logic                  c_in;

    logic                  valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out;
    logic [3:0]            exe_cmd_out;
    logic [DATA_W-1:0]     pc_out, val_rn_out, val_rm_out;
    logic                  imm_out;
    logic [11:0]           shift_operand_out;
    logic [23:0]           signed_imm_24_out;
    logic [REG_ADDR_W-1:0] dest_out, src1_out, src2_out;
    logic                  c_out;

    int totalCount = 0;
    int badCount   = 0;
    bit checkEn    = 1'b0;

    // Expected contents of the stage register
    logic                  expValid, expWb, expMr, expMw, expB, expS;
    logic [3:0]            expCmd;
    logic [DATA_W-1:0]     expPc, expRn, expRm;
    logic                  expImm;
    logic [11:0]           expShift;
    logic [23:0]           expSimm;
    logic [REG_ADDR_W-1:0] expDest, expSrc1, expSrc2;
    logic                  expC;

    id_ex_stage_reg #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .valid_in(valid_in),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .b_in(b_in), .s_in(s_in), .exe_cmd_in(exe_cmd_in), .pc_in(pc_in),
        .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .imm_in(imm_in),
        .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
        .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .c_in(c_in),
        .valid_out(valid_out), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
        .mem_w_en_out(mem_w_en_out), .b_out(b_out), .s_out(s_out),
        .exe_cmd_out(exe_cmd_out), .pc_out(pc_out), .val_rn_out(val_rn_out),
        .val_rm_out(val_rm_out), .imm_out(imm_out),
        .shift_operand_out(shift_operand_out), .signed_imm_24_out(signed_imm_24_out),
        .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out), .c_out(c_out)
    );

    always #5 clk = ~clk;

    // Behavioural model: a bubble or reset empties the slot, a stall keeps it,
    // otherwise the slot takes the decode contents with a bubble's controls dead
    always @(posedge clk) begin
        if (rst || flush) begin
            {expValid, expWb, expMr, expMw, expB, expS, expCmd} = '0;
            {expPc, expRn, expRm, expImm, expShift, expSimm} = '0;
            {expDest, expSrc1, expSrc2, expC} = '0;
        end else if (!freeze) begin
            expValid = valid_in;
            expWb    = valid_in && wb_en_in;
            expMr    = valid_in && mem_r_en_in;
            expMw    = valid_in && mem_w_en_in;
            expB     = valid_in && b_in;
            expS     = valid_in && s_in;
            expCmd   = valid_in ? exe_cmd_in : 4'd0;
            expPc    = pc_in;
            expRn    = val_rn_in;
            expRm    = val_rm_in;
            expImm   = imm_in;
            expShift = shift_operand_in;
            expSimm  = signed_imm_24_in;
            expDest  = dest_in;
            expSrc1  = src1_in;
            expSrc2  = src2_in;
            expC     = c_in;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        totalCount++;
        if (actual !== expected) begin
            badCount++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare every output against the model once per cycle
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("valid",    32'(valid_out),         32'(expValid));
            checkOutput("wb_en",    32'(wb_en_out),         32'(expWb));
            checkOutput("mem_r_en", 32'(mem_r_en_out),      32'(expMr));
            checkOutput("mem_w_en", 32'(mem_w_en_out),      32'(expMw));
            checkOutput("b",        32'(b_out),             32'(expB));
            checkOutput("s",        32'(s_out),             32'(expS));
            checkOutput("exe_cmd",  32'(exe_cmd_out),       32'(expCmd));
            checkOutput("pc",       pc_out,                 expPc);
            checkOutput("val_rn",   val_rn_out,             expRn);
            checkOutput("val_rm",   val_rm_out,             expRm);
            checkOutput("imm",      32'(imm_out),           32'(expImm));
            checkOutput("shift",    32'(shift_operand_out), 32'(expShift));
            checkOutput("simm24",   32'(signed_imm_24_out), 32'(expSimm));
            checkOutput("dest",     32'(dest_out),          32'(expDest));
            checkOutput("src1",     32'(src1_out),          32'(expSrc1));
            checkOutput("src2",     32'(src2_out),          32'(expSrc2));
            checkOutput("c",        32'(c_out),             32'(expC));
        end
    end

    task automatic applyStimulus(input logic rstV, input logic flushV, input logic freezeV,
                                 input logic validV);
        rst      = rstV;
        flush    = flushV;
        freeze   = freezeV;
        valid_in = validV;
    endtask

    task automatic clearFields();
        {wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, exe_cmd_in} = '0;
        {pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in, signed_imm_24_in} = '0;
        {dest_in, src1_in, src2_in, c_in} = '0;
    endtask

    task automatic driveRandom();
        applyStimulus(($urandom_range(31) == 0), ($urandom_range(7) == 0),
                      ($urandom_range(3) == 0), 1'($urandom()));
        wb_en_in         = 1'($urandom());
        mem_r_en_in      = 1'($urandom());
        mem_w_en_in      = 1'($urandom());
        b_in             = 1'($urandom());
        s_in             = 1'($urandom());
        exe_cmd_in       = 4'($urandom());
        pc_in            = $urandom();
        val_rn_in        = $urandom();
        val_rm_in        = $urandom();
        imm_in           = 1'($urandom());
        shift_operand_in = 12'($urandom());
        signed_imm_24_in = 24'($urandom());
        dest_in          = 4'($urandom());
        src1_in          = 4'($urandom());
        src2_in          = 4'($urandom());
        c_in             = 1'($urandom());
    endtask

    // Directed scenarios, then randomized traffic, then the summary
    initial begin
        // Reset with every input driven high
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        {wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, exe_cmd_in} = '1;
        {pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in, signed_imm_24_in} = '1;
        {dest_in, src1_in, src2_in, c_in} = '1;
        @(negedge clk);
        checkEn = 1'b1;
        checkOutput("rst1_exe_cmd", 32'(exe_cmd_out), 32'h0);
        checkOutput("rst1_valid",   32'(valid_out),   32'h0);
        checkOutput("rst1_pc",      pc_out,           32'h0);
        @(negedge clk);
        checkOutput("rst2_exe_cmd", 32'(exe_cmd_out), 32'h0);
        checkOutput("rst2_c",       32'(c_out),       32'h0);

        // Plain load of a valid ADD
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        clearFields();
        exe_cmd_in = 4'b0010;
        wb_en_in   = 1'b1;
        val_rn_in  = 32'h0000_0005;
        dest_in    = 4'd3;
        @(negedge clk);
        checkOutput("load_valid",   32'(valid_out),   32'h1);
        checkOutput("load_exe_cmd", 32'(exe_cmd_out), 32'h2);
        checkOutput("load_wb_en",   32'(wb_en_out),   32'h1);
        checkOutput("load_val_rn",  val_rn_out,       32'h5);
        checkOutput("load_dest",    32'(dest_out),    32'h3);

        // Bubble from decode: controls forced dead, data still captured
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        wb_en_in    = 1'b1;
        mem_w_en_in = 1'b1;
        exe_cmd_in  = 4'b0100;
        val_rm_in   = 32'h0000_00AA;
        @(negedge clk);
        checkOutput("bub_wb_en",    32'(wb_en_out),    32'h0);
        checkOutput("bub_mem_w_en", 32'(mem_w_en_out), 32'h0);
        checkOutput("bub_exe_cmd",  32'(exe_cmd_out),  32'h0);
        checkOutput("bub_valid",    32'(valid_out),    32'h0);
        checkOutput("bub_val_rm",   val_rm_out,        32'hAA);

        // Freeze holds for three cycles, then the current input is loaded
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        clearFields();
        pc_in = 32'h10;
        @(negedge clk);
        checkOutput("frz_load_pc", pc_out, 32'h10);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
            pc_in = 32'h14 + 32'(4 * k);
            @(negedge clk);
            checkOutput("frz_hold_pc", pc_out, 32'h10);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        pc_in = 32'h20;
        @(negedge clk);
        checkOutput("frz_release_pc", pc_out, 32'h20);

        // Flush beats freeze
        exe_cmd_in = 4'b0010;
        wb_en_in   = 1'b1;
        val_rn_in  = 32'h7;
        val_rm_in  = 32'h9;
        pc_in      = 32'h24;
        dest_in    = 4'd2;
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("fl_valid",   32'(valid_out),   32'h0);
        checkOutput("fl_wb_en",   32'(wb_en_out),   32'h0);
        checkOutput("fl_exe_cmd", 32'(exe_cmd_out), 32'h0);
        checkOutput("fl_val_rn",  val_rn_out,       32'h0);
        checkOutput("fl_pc",      pc_out,           32'h0);

        // Reset in the middle of a stall holding a store
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        clearFields();
        mem_w_en_in = 1'b1;
        exe_cmd_in  = 4'b0010;
        src2_in     = 4'd5;
        val_rm_in   = 32'hAB;
        @(negedge clk);
        checkOutput("rmf_store", 32'(mem_w_en_out), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("rmf_held", 32'(mem_w_en_out), 32'h1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("rmf_mem_w_en", 32'(mem_w_en_out), 32'h0);
        checkOutput("rmf_val_rm",   val_rm_out,        32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        clearFields();
        pc_in = 32'h44;
        @(negedge clk);
        checkOutput("rmf_reload_pc", pc_out, 32'h44);

        // Randomized traffic checked by the model every cycle
        repeat (400) begin
            driveRandom();
            @(negedge clk);
        end

        checkEn = 1'b0;
        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
